// File: rtl/ss_pkg.sv
// Shared constants and payload types for the seven-segment PWM driver.
package ss_pkg;

  localparam int unsigned NUM_DIGITS = 4;
  localparam int unsigned IDX_W      = 2;
  localparam int unsigned BCD_W      = 4;
  localparam int unsigned SEG_W      = 8;
  localparam int unsigned PWM_W      = 4;

  // Active-low cathode codes {dp,g,f,e,d,c,b,a}; entry n is the glyph for BCD n.
  localparam logic [9:0][SEG_W-1:0] SEG_CODES = {
    8'h90, 8'h80, 8'hF8, 8'h82, 8'h92,
    8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
  };
  localparam logic [SEG_W-1:0] SEG_BLANK = 8'hFF;

  // Frame-stable copy of everything the display shows.
  typedef struct packed {
    logic [BCD_W-1:0]      d3;
    logic [BCD_W-1:0]      d2;
    logic [BCD_W-1:0]      d1;
    logic [BCD_W-1:0]      d0;
    logic [NUM_DIGITS-1:0] dp;
    logic [PWM_W-1:0]      bright;
  } shadow_t;

endpackage

// File: rtl/ss_pwm_driver_if.sv
// Display bus: digit/brightness request in, anode/cathode drive out.
interface ss_pwm_driver_if;
  import ss_pkg::*;

  logic [BCD_W-1:0]      digit3;
  logic [BCD_W-1:0]      digit2;
  logic [BCD_W-1:0]      digit1;
  logic [BCD_W-1:0]      digit0;
  logic [NUM_DIGITS-1:0] dp;
  logic [PWM_W-1:0]      brightness;
  logic [NUM_DIGITS-1:0] segment_drivers;
  logic [SEG_W-1:0]      seven_segment;

  modport master (
    output digit3, digit2, digit1, digit0, dp, brightness,
    input  segment_drivers, seven_segment
  );

  modport slave (
    input  digit3, digit2, digit1, digit0, dp, brightness,
    output segment_drivers, seven_segment
  );
endinterface

// File: rtl/bcd_to_seg.sv
// Combinational BCD to active-low seven-segment decoder; 10..15 blank.
module bcd_to_seg
  import ss_pkg::*;
(
  input  logic [BCD_W-1:0] bcd,
  output logic [SEG_W-1:0] seg_c
);

  // Table lookup with blank fallback for non-decimal codes.
  always_comb begin
    seg_c = SEG_BLANK;
    for (int i = 0; i < 10; i++) begin
      if (bcd == BCD_W'(i)) seg_c = SEG_CODES[i];
    end
  end

endmodule

// File: rtl/ss_pwm_driver.sv
// Four-digit multiplexed seven-segment driver with PWM brightness and
// frame-synchronous input capture.
module ss_pwm_driver
  import ss_pkg::*;
#(
  parameter int unsigned REFRESH_DIV = 100000,
  parameter bit          LEAD_BLANK  = 1'b0
) (
  input  logic                  CLK100MHZ,
  input  logic                  Reset,
  input  logic [BCD_W-1:0]      Digit3,
  input  logic [BCD_W-1:0]      Digit2,
  input  logic [BCD_W-1:0]      Digit1,
  input  logic [BCD_W-1:0]      Digit0,
  input  logic [NUM_DIGITS-1:0] DP,
  input  logic [PWM_W-1:0]      Brightness,
  output logic [NUM_DIGITS-1:0] SegmentDrivers,
  output logic [SEG_W-1:0]      SevenSegment
);

  localparam int unsigned PRESC_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0]   IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

  logic [PRESC_W-1:0]    presc;
  logic [IDX_W-1:0]      idx;
  logic [PWM_W-1:0]      pwm_cnt;
  shadow_t               shadow;

  logic                  slot_tick_c;
  logic                  frame_tick_c;
  logic [BCD_W-1:0]      sel_bcd_c;
  logic                  sel_dp_c;
  logic [SEG_W-1:0]      dec_seg_c;
  logic [SEG_W-1:0]      seg_next_c;
  logic [NUM_DIGITS-1:0] drv_next_c;

  assign slot_tick_c  = (presc == PRESC_LAST);
  assign frame_tick_c = slot_tick_c && (idx == IDX_LAST);

  // Slot prescaler, digit index, PWM phase and frame-boundary shadow capture.
  always_ff @(posedge CLK100MHZ) begin
    if (Reset) begin
      presc   <= '0;
      idx     <= '0;
      pwm_cnt <= '0;
      shadow  <= '0;
    end else begin
      pwm_cnt <= pwm_cnt + PWM_W'(1);
      if (slot_tick_c) begin
        presc <= '0;
        idx   <= idx + IDX_W'(1);
      end else begin
        presc <= presc + PRESC_W'(1);
      end
      if (frame_tick_c) begin
        shadow.d3     <= Digit3;
        shadow.d2     <= Digit2;
        shadow.d1     <= Digit1;
        shadow.d0     <= Digit0;
        shadow.dp     <= DP;
        shadow.bright <= Brightness;
      end
    end
  end

  // Select the shadowed digit and decimal point for the active slot.
  always_comb begin
    sel_bcd_c = shadow.d0;
    case (idx)
      2'd1:    sel_bcd_c = shadow.d1;
      2'd2:    sel_bcd_c = shadow.d2;
      2'd3:    sel_bcd_c = shadow.d3;
      default: sel_bcd_c = shadow.d0;
    endcase
    sel_dp_c = shadow.dp[idx];
  end

  bcd_to_seg u_bcd_to_seg (
    .bcd   (sel_bcd_c),
    .seg_c (dec_seg_c)
  );

  // Cathode pattern: optional leading-zero blank, then decimal point overlay.
  always_comb begin
    seg_next_c = dec_seg_c;
    if (LEAD_BLANK && (idx == IDX_LAST) && (shadow.d3 == '0)) begin
      seg_next_c = SEG_BLANK;
    end
    if (sel_dp_c) seg_next_c[SEG_W-1] = 1'b0;
  end

  // Anode pattern: dark on the first clock of a slot and outside the PWM window.
  always_comb begin
    drv_next_c = '1;
    if ((presc != '0) && (pwm_cnt < shadow.bright)) begin
      drv_next_c[idx] = 1'b0;
    end
  end

  // Registered pin drive.
  always_ff @(posedge CLK100MHZ) begin
    if (Reset) begin
      SegmentDrivers <= '1;
      SevenSegment   <= SEG_BLANK;
    end else begin
      SegmentDrivers <= drv_next_c;
      SevenSegment   <= seg_next_c;
    end
  end

endmodule
